// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl_if
// Description : Hazard-controller bus: ID/EXE hazard operands, data-memory
//               handshake, CP0 exception request and pipeline enable/flush
//               controls.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_hazard_ctrl_if;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic       exe_mem_rd;
    logic [4:0] exe_wb_dreg;
    logic       exe_bj;
    logic       mem_rd;
    logic       mem_we;
    logic       mem_ack;
    logic       exc_req;

    logic       pc_en;
    logic       pc_exc_sel;
    logic       if_id_en;
    logic       id_exe_en;
    logic       exe_mem_en;
    logic       mem_wb_en;
    logic       if_id_flush;
    logic       id_exe_flush;
    logic       exe_mem_flush;
    logic       mem_wb_flush;
    logic       mem_req;
    logic       bus_err;

    // Controller side
    modport master (
        input  id_rs, id_rt, id_use_rs, id_use_rt, exe_mem_rd, exe_wb_dreg,
               exe_bj, mem_rd, mem_we, mem_ack, exc_req,
        output pc_en, pc_exc_sel, if_id_en, id_exe_en, exe_mem_en, mem_wb_en,
               if_id_flush, id_exe_flush, exe_mem_flush, mem_wb_flush,
               mem_req, bus_err
    );

    // Pipeline / memory side
    modport slave (
        output id_rs, id_rt, id_use_rs, id_use_rt, exe_mem_rd, exe_wb_dreg,
               exe_bj, mem_rd, mem_we, mem_ack, exc_req,
        input  pc_en, pc_exc_sel, if_id_en, id_exe_en, exe_mem_en, mem_wb_en,
               if_id_flush, id_exe_flush, exe_mem_flush, mem_wb_flush,
               mem_req, bus_err
    );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Pipeline sequencer. Resolves exception > memory wait >
//               branch > load-use into per-stage enables/flushes, runs the
//               data-memory handshake with a timeout, counts stall cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    pipe_hazard_ctrl_if.master    bus,
    input  wire logic             stall_clr,
    output logic [CNT_W-1:0]      stall_cnt
);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

    state_t             state_q, state_d;
    logic [7:0]         wait_cnt_q, wait_cnt_d;
    logic               bus_err_q, bus_err_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic               acc;
    logic               load_use;

    assign acc = bus.mem_rd | bus.mem_we;

    // A load in EXE whose (non-zero) destination feeds a source the ID instruction actually reads
    assign load_use = bus.exe_mem_rd && (bus.exe_wb_dreg != 5'd0) &&
                      ((bus.id_use_rs && (bus.id_rs == bus.exe_wb_dreg)) ||
                       (bus.id_use_rt && (bus.id_rt == bus.exe_wb_dreg)));

    // State, wait counter and bus-error registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            wait_cnt_q  <= 8'd0;
            bus_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            bus_err_q   <= bus_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Next state and prioritised pipeline controls; everything forced low in reset
    always_comb begin
        state_d           = state_q;
        wait_cnt_d        = wait_cnt_q;
        bus_err_d         = 1'b0;
        bus.pc_en         = 1'b1;
        bus.pc_exc_sel    = 1'b0;
        bus.if_id_en      = 1'b1;
        bus.id_exe_en     = 1'b1;
        bus.exe_mem_en    = 1'b1;
        bus.mem_wb_en     = 1'b1;
        bus.if_id_flush   = 1'b0;
        bus.id_exe_flush  = 1'b0;
        bus.exe_mem_flush = 1'b0;
        bus.mem_wb_flush  = 1'b0;
        bus.mem_req       = acc;

        case (state_q)
            RUN: begin
                if (bus.exc_req) begin
                    // Redirect to the vector and squash every stage, including the faulting one
                    bus.pc_exc_sel    = 1'b1;
                    bus.if_id_flush   = 1'b1;
                    bus.id_exe_flush  = 1'b1;
                    bus.exe_mem_flush = 1'b1;
                    bus.mem_wb_flush  = 1'b1;
                    bus.mem_req       = 1'b0;
                end else if (acc && !bus.mem_ack) begin
                    bus.pc_en        = 1'b0;
                    bus.if_id_en     = 1'b0;
                    bus.id_exe_en    = 1'b0;
                    bus.exe_mem_en   = 1'b0;
                    bus.mem_wb_flush = 1'b1;
                    state_d          = MEM_WAIT;
                    wait_cnt_d       = 8'd1;
                end else if (bus.exe_bj) begin
                    bus.if_id_flush  = 1'b1;
                    bus.id_exe_flush = 1'b1;
                end else if (load_use) begin
                    // Hold IF/ID one cycle and send a bubble into EXE
                    bus.pc_en        = 1'b0;
                    bus.if_id_en     = 1'b0;
                    bus.id_exe_flush = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (bus.mem_ack) begin
                    state_d    = RUN;
                    wait_cnt_d = 8'd0;
                end else begin
                    bus.pc_en        = 1'b0;
                    bus.if_id_en     = 1'b0;
                    bus.id_exe_en    = 1'b0;
                    bus.exe_mem_en   = 1'b0;
                    bus.mem_wb_flush = 1'b1;
                    if (wait_cnt_q == TIMEOUT_C) begin
                        // Give up; CP0 turns the stalled access into an exception
                        bus_err_d  = 1'b1;
                        state_d    = RUN;
                        wait_cnt_d = 8'd0;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = 8'd0;
            end
        endcase

        if (!rst_n) begin
            bus.pc_en         = 1'b0;
            bus.pc_exc_sel    = 1'b0;
            bus.if_id_en      = 1'b0;
            bus.id_exe_en     = 1'b0;
            bus.exe_mem_en    = 1'b0;
            bus.mem_wb_en     = 1'b0;
            bus.if_id_flush   = 1'b0;
            bus.id_exe_flush  = 1'b0;
            bus.exe_mem_flush = 1'b0;
            bus.mem_wb_flush  = 1'b0;
            bus.mem_req       = 1'b0;
        end
    end

    // Saturating count of cycles the PC is held; clear wins over increment
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_clr) begin
            stall_cnt_d = '0;
        end else if (!bus.pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    assign bus.bus_err = bus_err_q;
    assign stall_cnt   = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Self-checking bench; directed scenarios plus random traffic
//               against a rule-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int TMO = 4;
    localparam int CW  = 3;
    localparam int SAT = (1 << CW) - 1;

    localparam int EV_GO  = 0;
    localparam int EV_EXC = 1;
    localparam int EV_MEM = 2;
    localparam int EV_BJ  = 3;
    localparam int EV_LU  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          stall_clr = 1'b0;
    logic [CW-1:0] stall_cnt;

    pipe_hazard_ctrl_if bus();

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .stall_clr (stall_clr),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: whether a memory access is outstanding, how many
    // cycles it has spent waiting, the bus-error flag and the stall count.
    bit          m_waiting  = 1'b0;
    int          m_wait_len = 0;
    bit          m_bus_err  = 1'b0;
    int          m_stall    = 0;
    int          m_ev       = EV_GO;
    logic [10:0] exp_ctl    = '0;

    // {pc_en, pc_exc_sel, if_id_en, id_exe_en, exe_mem_en, mem_wb_en,
    //  if_id_flush, id_exe_flush, exe_mem_flush, mem_wb_flush, mem_req}
    function automatic logic [10:0] act_ctl();
        return {bus.pc_en, bus.pc_exc_sel, bus.if_id_en, bus.id_exe_en,
                bus.exe_mem_en, bus.mem_wb_en, bus.if_id_flush, bus.id_exe_flush,
                bus.exe_mem_flush, bus.mem_wb_flush, bus.mem_req};
    endfunction

    task automatic idle();
        bus.id_rs = 5'd0; bus.id_rt = 5'd0; bus.id_use_rs = 1'b0; bus.id_use_rt = 1'b0;
        bus.exe_mem_rd = 1'b0; bus.exe_wb_dreg = 5'd0; bus.exe_bj = 1'b0;
        bus.mem_rd = 1'b0; bus.mem_we = 1'b0; bus.mem_ack = 1'b0; bus.exc_req = 1'b0;
        stall_clr = 1'b0;
    endtask

    // Pick the winning event for the current inputs and form the expected controls
    task automatic settle();
        bit acc, hit;
        if (!rst_n) begin
            m_waiting = 1'b0; m_wait_len = 0; m_bus_err = 1'b0; m_stall = 0;
            m_ev = EV_GO; exp_ctl = '0;
            return;
        end
        acc = bus.mem_rd | bus.mem_we;
        hit = bus.exe_mem_rd && (bus.exe_wb_dreg != 0) &&
              ((bus.id_use_rs && bus.id_rs == bus.exe_wb_dreg) ||
               (bus.id_use_rt && bus.id_rt == bus.exe_wb_dreg));
        if (m_waiting)                   m_ev = bus.mem_ack ? EV_GO : EV_MEM;
        else if (bus.exc_req)            m_ev = EV_EXC;
        else if (acc && !bus.mem_ack)    m_ev = EV_MEM;
        else if (bus.exe_bj)             m_ev = EV_BJ;
        else if (hit)                    m_ev = EV_LU;
        else                             m_ev = EV_GO;
        case (m_ev)
            EV_EXC:  exp_ctl = 11'b11111111110;
            EV_MEM:  exp_ctl = {10'b0000010001, acc};
            EV_BJ:   exp_ctl = {10'b1011111100, acc};
            EV_LU:   exp_ctl = {10'b0001110100, acc};
            default: exp_ctl = {10'b1011110000, acc};
        endcase
    endtask

    // Advance one clock and update the model from the cycle's outcome
    task automatic tick();
        bit timeout;
        int nstall;
        timeout = m_waiting && !bus.mem_ack && (m_wait_len == TMO);
        if (stall_clr)                           nstall = 0;
        else if (!exp_ctl[10] && m_stall < SAT)  nstall = m_stall + 1;
        else                                     nstall = m_stall;
        @(posedge clk);
        if (rst_n) begin
            m_bus_err = timeout;
            m_stall   = nstall;
            if (m_ev == EV_MEM) begin
                if (!m_waiting) begin m_waiting = 1'b1; m_wait_len = 1; end
                else if (timeout) begin m_waiting = 1'b0; m_wait_len = 0; end
                else m_wait_len++;
            end else begin
                m_waiting = 1'b0; m_wait_len = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        idle();
        bus.mem_rd = 1'b1;
        #1 rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle();
            @(negedge clk);
            n_cmp++; if (act_ctl() !== 11'b0) begin n_bad++; $display("FAIL reset_ctl: got %b want %b", act_ctl(), 11'b0); end
            n_cmp++; if (stall_cnt !== '0) begin n_bad++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
            n_cmp++; if (bus.bus_err !== 1'b0) begin n_bad++; $display("FAIL reset_bus_err: got %b want 0", bus.bus_err); end
            tick();
        end
        rst_n = 1'b1;
        idle();
        settle();
        @(negedge clk);
        n_cmp++; if (act_ctl() !== 11'b10111100000) begin n_bad++; $display("FAIL reset_release: got %b want %b", act_ctl(), 11'b10111100000); end
        tick();
    endtask

    task automatic test_load_use();
        // dreg, rs, rt, use_rs, use_rt
        logic [4:0] tab [4][3];
        logic [1:0] use_tab [4];
        tab[0] = '{5'd5, 5'd5, 5'd0}; use_tab[0] = 2'b10;
        tab[1] = '{5'd0, 5'd0, 5'd0}; use_tab[1] = 2'b11;
        tab[2] = '{5'd7, 5'd3, 5'd7}; use_tab[2] = 2'b01;
        tab[3] = '{5'd7, 5'd7, 5'd3}; use_tab[3] = 2'b01;
        for (int t = 0; t < 4; t++) begin
            for (int c = 0; c < 2; c++) begin
                idle();
                if (c == 0) begin
                    bus.exe_mem_rd = 1'b1; bus.exe_wb_dreg = tab[t][0];
                    bus.id_rs = tab[t][1]; bus.id_rt = tab[t][2];
                    bus.id_use_rs = use_tab[t][1]; bus.id_use_rt = use_tab[t][0];
                end
                settle();
                @(negedge clk);
                n_cmp++; if (act_ctl() !== exp_ctl) begin n_bad++; $display("FAIL load_use_ctl[%0d.%0d]: got %b want %b", t, c, act_ctl(), exp_ctl); end
                n_cmp++; if (stall_cnt !== CW'(m_stall)) begin n_bad++; $display("FAIL load_use_stall_cnt[%0d.%0d]: got %0d want %0d", t, c, stall_cnt, m_stall); end
                tick();
            end
        end
        // Only patterns 0 and 2 are real hazards
        n_cmp++; if (stall_cnt !== CW'(2)) begin n_bad++; $display("FAIL load_use_total: got %0d want 2", stall_cnt); end
    endtask

    task automatic test_mem_wait();
        for (int c = 0; c < 6; c++) begin
            idle();
            if (c == 0) stall_clr = 1'b1;
            if (c >= 1 && c <= 4) bus.mem_rd = 1'b1;
            if (c == 4) bus.mem_ack = 1'b1;
            settle();
            @(negedge clk);
            n_cmp++; if (act_ctl() !== exp_ctl) begin n_bad++; $display("FAIL mem_wait_ctl[%0d]: got %b want %b", c, act_ctl(), exp_ctl); end
            n_cmp++; if (stall_cnt !== CW'(m_stall)) begin n_bad++; $display("FAIL mem_wait_stall_cnt[%0d]: got %0d want %0d", c, stall_cnt, m_stall); end
            if (c == 4) begin
                n_cmp++; if (act_ctl() !== 11'b10111100001) begin n_bad++; $display("FAIL mem_wait_ack: got %b want %b", act_ctl(), 11'b10111100001); end
            end
            tick();
        end
        n_cmp++; if (stall_cnt !== CW'(3)) begin n_bad++; $display("FAIL mem_wait_total: got %0d want 3", stall_cnt); end
    endtask

    task automatic test_zero_wait_branch();
        idle();
        bus.mem_we = 1'b1; bus.mem_ack = 1'b1; bus.exe_bj = 1'b1;
        bus.exe_mem_rd = 1'b1; bus.exe_wb_dreg = 5'd9; bus.id_rt = 5'd9; bus.id_use_rt = 1'b1;
        settle();
        @(negedge clk);
        n_cmp++; if (act_ctl() !== 11'b10111111001) begin n_bad++; $display("FAIL zero_wait_branch: got %b want %b", act_ctl(), 11'b10111111001); end
        n_cmp++; if (act_ctl() !== exp_ctl) begin n_bad++; $display("FAIL zero_wait_branch_model: got %b want %b", act_ctl(), exp_ctl); end
        tick();
    endtask

    task automatic test_exc_priority();
        idle();
        bus.exc_req = 1'b1; bus.exe_bj = 1'b1; bus.mem_rd = 1'b1; bus.mem_ack = 1'b0;
        settle();
        @(negedge clk);
        n_cmp++; if (act_ctl() !== 11'b11111111110) begin n_bad++; $display("FAIL exc_priority: got %b want %b", act_ctl(), 11'b11111111110); end
        tick();
        idle();
        settle();
        @(negedge clk);
        n_cmp++; if (act_ctl() !== 11'b10111100000) begin n_bad++; $display("FAIL exc_stays_run: got %b want %b", act_ctl(), 11'b10111100000); end
        tick();
    endtask

    task automatic test_timeout();
        int pulses = 0;
        for (int c = 0; c < 9; c++) begin
            idle();
            if (c >= 1 && c <= 5) bus.mem_rd = 1'b1;
            if (c == 0 || c == 3) stall_clr = 1'b1;
            settle();
            @(negedge clk);
            if (bus.bus_err === 1'b1) pulses++;
            n_cmp++; if (act_ctl() !== exp_ctl) begin n_bad++; $display("FAIL timeout_ctl[%0d]: got %b want %b", c, act_ctl(), exp_ctl); end
            n_cmp++; if (bus.bus_err !== m_bus_err) begin n_bad++; $display("FAIL timeout_bus_err[%0d]: got %b want %b", c, bus.bus_err, m_bus_err); end
            n_cmp++; if (stall_cnt !== CW'(m_stall)) begin n_bad++; $display("FAIL timeout_stall_cnt[%0d]: got %0d want %0d", c, stall_cnt, m_stall); end
            if (c == 4) begin
                n_cmp++; if (stall_cnt !== CW'(0)) begin n_bad++; $display("FAIL timeout_stall_clr: got %0d want 0", stall_cnt); end
            end
            tick();
        end
        n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL timeout_pulse_count: got %0d want 1", pulses); end
    endtask

    task automatic test_saturation();
        for (int c = 0; c < 14; c++) begin
            idle();
            if (c >= 1 && c <= 12) bus.mem_rd = 1'b1;
            if (c == 0) stall_clr = 1'b1;
            settle();
            @(negedge clk);
            n_cmp++; if (act_ctl() !== exp_ctl) begin n_bad++; $display("FAIL sat_ctl[%0d]: got %b want %b", c, act_ctl(), exp_ctl); end
            n_cmp++; if (stall_cnt !== CW'(m_stall)) begin n_bad++; $display("FAIL sat_stall_cnt[%0d]: got %0d want %0d", c, stall_cnt, m_stall); end
            tick();
        end
        n_cmp++; if (stall_cnt !== CW'(SAT)) begin n_bad++; $display("FAIL sat_hold: got %0d want %0d", stall_cnt, SAT); end
    endtask

    task automatic test_reset_mid_wait();
        for (int c = 0; c < 3; c++) begin
            idle();
            bus.mem_rd = 1'b1;
            settle();
            tick();
        end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (act_ctl() !== 11'b0) begin n_bad++; $display("FAIL mid_wait_reset_ctl: got %b want %b", act_ctl(), 11'b0); end
        n_cmp++; if (stall_cnt !== '0) begin n_bad++; $display("FAIL mid_wait_reset_cnt: got %0d want 0", stall_cnt); end
        settle();
        tick();
        rst_n = 1'b1;
        idle();
        settle();
        @(negedge clk);
        n_cmp++; if (act_ctl() !== 11'b10111100000) begin n_bad++; $display("FAIL mid_wait_back_to_run: got %b want %b", act_ctl(), 11'b10111100000); end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bus.id_rs       = 5'($urandom_range(0, 3));
            bus.id_rt       = 5'($urandom_range(0, 3));
            bus.id_use_rs   = 1'($urandom_range(0, 1));
            bus.id_use_rt   = 1'($urandom_range(0, 1));
            bus.exe_mem_rd  = 1'($urandom_range(0, 1));
            bus.exe_wb_dreg = 5'($urandom_range(0, 3));
            bus.exe_bj      = ($urandom_range(0, 4) == 0);
            bus.mem_rd      = ($urandom_range(0, 3) == 0);
            bus.mem_we      = ($urandom_range(0, 5) == 0);
            bus.mem_ack     = ($urandom_range(0, 5) == 0);
            bus.exc_req     = ($urandom_range(0, 12) == 0);
            stall_clr       = ($urandom_range(0, 15) == 0);
            settle();
            @(negedge clk);
            n_cmp++; if (act_ctl() !== exp_ctl) begin n_bad++; $display("FAIL random_ctl[%0d]: got %b want %b", c, act_ctl(), exp_ctl); end
            n_cmp++; if (bus.bus_err !== m_bus_err) begin n_bad++; $display("FAIL random_bus_err[%0d]: got %b want %b", c, bus.bus_err, m_bus_err); end
            n_cmp++; if (stall_cnt !== CW'(m_stall)) begin n_bad++; $display("FAIL random_stall_cnt[%0d]: got %0d want %0d", c, stall_cnt, m_stall); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mem_wait();
        test_zero_wait_branch();
        test_exc_priority();
        test_timeout();
        test_saturation();
        test_reset_mid_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central sequencer for the 5-stage pipeline registers (IF/ID, ID/EXE, EXE/MEM, MEM/WB) and the PC. Each cycle it decides the per-stage enable and flush signals from four sources, in priority order: CP0 exception, data-memory wait handshake, taken branch/jump in EXE, and load-use hazard. It also owns the data-memory request/acknowledge handshake, a wait-timeout bus-error detector, and a stall-cycle performance counter.

Parameters:
MEM_TIMEOUT, 16, max cycles spent in MEM_WAIT before bus_err is raised (legal range 1..255)
CNT_W, 32, width of stall_cnt

Ports:
clk  in  1  pipeline clock
rst_n  in  1  reset, asynchronous, active-low
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_use_rs  in  1  ID instruction reads rs
id_use_rt  in  1  ID instruction reads rt
exe_mem_rd  in  1  instruction in EXE is a load
exe_wb_dreg  in  5  destination register of EXE instruction
exe_bj  in  1  branch/jump taken, resolved in EXE
mem_rd  in  1  instruction in MEM reads data memory
mem_we  in  1  instruction in MEM writes data memory
mem_ack  in  1  data memory completes the access this cycle
exc_req  in  1  CP0 exception request for the instruction in MEM
stall_clr  in  1  synchronous clear of stall_cnt
pc_en  out  1  PC load enable
pc_exc_sel  out  1  PC selects the exception vector
if_id_en, id_exe_en, exe_mem_en, mem_wb_en  out  1 each  pipeline register enables
if_id_flush, id_exe_flush, exe_mem_flush, mem_wb_flush  out  1 each  synchronous clear of the register, takes effect at the next edge; dominates en
mem_req  out  1  data memory request
bus_err  out  1  one-cycle pulse on memory timeout
stall_cnt  out  CNT_W  saturating count of cycles with pc_en=0

Behaviour:
- Reset is asynchronous, asserted when rst_n=0. On reset: state=RUN, wait counter=0, bus_err=0, stall_cnt=0. While rst_n=0, all en, flush, pc_exc_sel and mem_req outputs are forced to 0.
- Control outputs are combinational from state and inputs. bus_err and stall_cnt are registered.
- Default in RUN: all en=1, all flush=0.
- acc = mem_rd | mem_we. mem_req = acc in both RUN and MEM_WAIT.
- Priority 1, exception (exc_req=1 in RUN):
  - pc_exc_sel=1, pc_en=1.
  - All four flushes=1. The faulting instruction never writes back.
  - Memory stall is ignored and mem_req=0. State stays RUN.
- Priority 2, memory wait:
  - Condition: RUN with acc=1 and mem_ack=0.
  - pc_en=if_id_en=id_exe_en=exe_mem_en=0.
  - mem_wb_flush=1, which inserts a WB bubble.
  - Next state is MEM_WAIT and the counter loads 1.
  - acc=1 with mem_ack=1 in the same cycle is a zero-wait access: no stall.
- MEM_WAIT:
  - Same outputs as the memory-wait stall; exc_req, exe_bj and load-use are ignored.
  - On mem_ack=1: all en=1, all flush=0, next state RUN, counter cleared.
  - Else, if counter==MEM_TIMEOUT: bus_err=1 at the next edge, next state RUN, counter cleared. The stalled instruction is then handled as an exception by CP0 via exc_req.
  - Otherwise the counter increments.
- Priority 3, branch (exe_bj=1 in RUN, no higher-priority event):
  - if_id_flush=1, id_exe_flush=1, pc_en=1.
- Priority 4, load-use (RUN, no higher-priority event):
  - Condition: exe_mem_rd=1, exe_wb_dreg≠0, and ((id_use_rs and id_rs==exe_wb_dreg) or (id_use_rt and id_rt==exe_wb_dreg)).
  - pc_en=0, if_id_en=0, id_exe_flush=1. Later stages advance. Lasts exactly one cycle.
- Branch plus load-use in the same cycle: branch wins and no stall is inserted.
- stall_cnt:
  - Increments each cycle that rst_n=1 and pc_en=0; saturates at all-ones.
  - stall_clr=1 clears it to 0, taking priority over increment.
- rst_n low mid-MEM_WAIT: immediately RUN; outputs as in reset.

Test Plan:
- Reset: rst_n=0 for 3 cycles with acc=1 → all en/flush/mem_req=0, stall_cnt=0. Release → all en=1, state RUN.
- Load-use: exe_mem_rd=1, exe_wb_dreg=5, id_rs=5, id_use_rs=1 → one cycle with pc_en=0, if_id_en=0, id_exe_flush=1, stall_cnt=1. Repeat with exe_wb_dreg=0 → no stall.
- Memory wait: mem_rd=1, mem_ack low 3 cycles then high → stall for 3 cycles (mem_wb_flush=1, mem_req=1). Ack cycle has all en=1, then RUN. stall_cnt=3.
- Zero-wait plus branch: mem_we=1, mem_ack=1, exe_bj=1 → no stall; if_id_flush=id_exe_flush=1, pc_en=1.
- Exception priority: exc_req=1, exe_bj=1, mem_rd=1, mem_ack=0 → pc_exc_sel=1, all four flushes=1, mem_req=0, state stays RUN.
- Timeout: MEM_TIMEOUT=4, mem_rd=1, mem_ack never → bus_err pulses for exactly 1 cycle after the 4th wait cycle, then RUN. Also check stall_clr mid-wait clears stall_cnt to 0, and stall_cnt saturation with CNT_W=3 holds at 7.
